// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite constants, responder FSM encoding and transfer helpers
// for the SRAM responder.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Naturally aligned byte/half/word only; anything wider is rejected.
    function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: return 1'b1;
            HSIZE_HALF: return ~a[0];
            HSIZE_WORD: return a == 2'b00;
            default:    return 1'b0;
        endcase
    endfunction

    // Byte lanes touched by a transfer within its 32-bit word.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: return 4'b0001 << a;
            HSIZE_HALF: return 4'b0011 << a;
            default:    return 4'b1111;
        endcase
    endfunction

    // Widen a 4-bit lane mask to a 32-bit bit mask.
    function automatic logic [31:0] lane_expand(input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

endpackage

// File: rtl/sram_bytewen.sv
// Word-organised SRAM with per-byte write enables and a registered read
// port. No reset: contents and read register power up undefined.
module sram_bytewen
    import ahb_lite_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wben,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [1 << AW];

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wben[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Registered read; a same-edge write to the same word is not visible here.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder in front of a byte-writable SRAM: pipelined single
// transfers, programmable wait states, two-cycle ERROR for illegal sizes or
// alignment, and write-to-read forwarding for back-to-back same-word access.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    slv_state_e    state_q, state_d;
    logic [3:0]    wcnt_q;
    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic [3:0]    mask_q;
    logic [3:0]    fwd_mask_q;
    logic [31:0]   fwd_data_q;
    logic [31:0]   hold_q;
    logic [31:0]   sram_q;

    logic          acc, legal, commit, rd_acc, rd_live;
    logic [AW-1:0] word;
    logic [31:0]   fwd_bits, merged;

    // High address bits alias and burst type is irrelevant for single transfers.
    logic unused_bits;
    assign unused_bits = ^{haddr[31:AW+2], hburst};

    // A new address phase is only taken while no data phase is stalling.
    assign acc     = hsel & htrans[1] & hready &
                     (state_q inside {ST_IDLE, ST_DATA, ST_ERR2});
    assign legal   = xfer_legal(hsize, haddr[1:0]);
    assign word    = haddr[AW+1:2];
    assign commit  = (state_q == ST_DATA) & wr_q;
    assign rd_acc  = acc & legal & ~hwrite;
    assign rd_live = (state_q == ST_DATA) & ~wr_q;

    assign fwd_bits = lane_expand(fwd_mask_q);
    assign merged   = (sram_q & ~fwd_bits) | (fwd_data_q & fwd_bits);

    sram_bytewen #(.AW(AW)) u_sram (
        .clk   (clk),
        .we    (commit & rstn),
        .wben  (mask_q),
        .waddr (addr_q),
        .wdata (hwdata),
        .re    (rd_acc & rstn),
        .raddr (word),
        .rdata (sram_q)
    );

    // State register and wait-state counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (acc)                                   wcnt_q <= 4'(WAIT_STATES - 1);
            else if (state_q == ST_WAIT && wcnt_q != '0) wcnt_q <= wcnt_q - 4'd1;
        end
    end

    // Next state: IDLE, DATA and ERR2 all follow the same accept rules.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (wcnt_q == '0) state_d = ST_DATA;
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (!acc)                 state_d = ST_IDLE;
                else if (!legal)          state_d = ST_ERR1;
                else if (WAIT_STATES > 0) state_d = ST_WAIT;
                else                      state_d = ST_DATA;
            end
        endcase
    end

    // Address-phase latch; illegal writes are demoted so they never commit.
    always_ff @(posedge clk) begin
        if (acc) begin
            addr_q <= word;
            wr_q   <= hwrite & legal;
            mask_q <= lane_mask(hsize, haddr[1:0]);
        end
    end

    // Capture lanes a committing write puts into the word a read just fetched.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else if (rd_acc) begin
            fwd_mask_q <= (commit && addr_q == word) ? mask_q : 4'b0000;
            fwd_data_q <= hwdata;
        end
    end

    // Hold the last completed read so writes and idles leave hrdata alone.
    always_ff @(posedge clk) begin
        if (!rstn)        hold_q <= '0;
        else if (rd_live) hold_q <= merged;
    end

    // Outputs decoded from registered state only.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
        hrdata = rd_live ? merged : hold_q;
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: a zero-wait and a three-wait instance are
// driven by a pipelined AHB master and scored against a word-array model in
// which a transfer takes effect when its data phase completes.
module tb_ahb_lite_sram_slave;
    import ahb_lite_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int WS1   = 3;

    typedef struct {
        int          kind;   // 0 transfer, 1 IDLE, 2 BUSY, 3 unselected
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rstn      [2];
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    int          n_chk  = 0;
    int          n_fail = 0;
    xfer_t       xq[$];
    logic [31:0] mdl [2][DEPTH];

    always #5 clk = ~clk;

    ahb_lite_sram_slave #(.AW(AW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rstn(rstn[0]), .hsel(hsel[0]), .haddr(haddr[0]),
        .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]),
        .hburst(hburst[0]), .hwdata(hwdata[0]), .hready(hreadyout[0]),
        .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0])
    );

    ahb_lite_sram_slave #(.AW(AW), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .rstn(rstn[1]), .hsel(hsel[1]), .haddr(haddr[1]),
        .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]),
        .hburst(hburst[1]), .hwdata(hwdata[1]), .hready(hreadyout[1]),
        .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit f_legal(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        return (a % (32'd1 << s)) == 32'd0;
    endfunction

    function automatic int f_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic mdl_write(input int d, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] w);
        int idx;
        int off;
        idx = f_idx(a);
        off = int'(a % 4);
        for (int k = 0; k < (1 << s); k++)
            mdl[d][idx][8*(off+k) +: 8] = w[8*(off+k) +: 8];
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic wr,
                        input logic [2:0] s, input logic [31:0] w);
        xfer_t x;
        x.kind = kind; x.addr = a; x.wr = wr; x.size = s; x.wdata = w;
        xq.push_back(x);
    endtask

    task automatic drive_idle(input int d);
        hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0;
        hsize[d] = 3'd0; haddr[d] = '0; hburst[d] = '0; hwdata[d] = '0;
    endtask

    task automatic push_rand(input int n);
        int          sz;
        int          off;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                push(int'($urandom_range(1, 3)), '0, 1'b0, 3'd0, '0);
            end else begin
                sz  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(3, 7))
                                                   : int'($urandom_range(0, 2));
                off = int'($urandom_range(0, 3));
                if ($urandom_range(0, 7) != 0) off = off & ~((1 << sz) - 1);
                a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'(off);
                push(0, a, 1'($urandom), 3'(sz), $urandom);
            end
        end
    endtask

    // Pipelined master: address phase of the queue head overlaps the data
    // phase of the previous transfer; cancels to IDLE after an ERROR's first cycle.
    task automatic run_q(input int d);
        xfer_t       dp, cur;
        bit          have_dp, was_err1, drove, exp_err;
        int          low, guard, ws;
        logic        rdy, rsp;
        logic [31:0] rd;
        have_dp = 0; was_err1 = 0; low = 0; guard = 0;
        ws = (d == 0) ? 0 : WS1;
        while ((xq.size() > 0 || have_dp) && guard < 20000) begin
            guard++;
            drove = !was_err1 && xq.size() > 0;
            hsel[d] = 1'b1; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'($urandom);
            hsize[d] = 3'($urandom); haddr[d] = $urandom; hburst[d] = 3'($urandom);
            if (drove) begin
                cur = xq[0];
                case (cur.kind)
                    0: begin
                        htrans[d] = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
                        haddr[d] = cur.addr; hwrite[d] = cur.wr; hsize[d] = cur.size;
                    end
                    1: htrans[d] = HTRANS_IDLE;
                    2: htrans[d] = HTRANS_BUSY;
                    default: begin
                        hsel[d] = 1'b0; htrans[d] = HTRANS_NONSEQ;
                    end
                endcase
            end
            hwdata[d] = (have_dp && dp.wr) ? dp.wdata : $urandom;
            @(negedge clk);
            rdy = hreadyout[d]; rsp = hresp[d]; rd = hrdata[d];
            if (have_dp) begin
                exp_err = !f_legal(dp.addr, dp.size);
                chk("dp_hresp", 32'(rsp), 32'(exp_err));
                if (!rdy) begin
                    low++;
                end else begin
                    chk("wait_cycles", low, exp_err ? 1 : ws);
                    if (!exp_err && !dp.wr) chk("hrdata", rd, mdl[d][f_idx(dp.addr)]);
                    if (!exp_err && dp.wr)  mdl_write(d, dp.addr, dp.size, dp.wdata);
                    have_dp = 0;
                end
            end else begin
                chk("idle_hreadyout", 32'(rdy), 32'd1);
                chk("idle_hresp", 32'(rsp), 32'd0);
            end
            was_err1 = !rdy && rsp;
            if (drove && rdy) begin
                void'(xq.pop_front());
                if (cur.kind == 0) begin
                    dp = cur; have_dp = 1; low = 0;
                end
            end
            @(posedge clk); #1;
        end
        if (guard >= 20000) begin
            chk("run_guard", guard, 0);
            xq.delete();
        end
        drive_idle(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0;
            drive_idle(d);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_hreadyout", 32'(hreadyout[d]), 32'd1);
            chk("rst_hresp", 32'(hresp[d]), 32'd0);
            chk("rst_hrdata", hrdata[d], 32'd0);
            rstn[d] = 1'b1;
        end
        @(posedge clk); #1;

        // Zero-wait instance: fill, directed cases, then random traffic.
        for (int i = 0; i < 32; i++) push(0, 32'(i * 4), 1'b1, HSIZE_WORD, $urandom);
        push(0, 32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
        push(1, '0, 1'b0, 3'd0, '0);
        push(0, 32'h10, 1'b0, HSIZE_WORD, '0);
        push(0, 32'h10, 1'b1, HSIZE_WORD, 32'h11223344);
        push(0, 32'h13, 1'b1, HSIZE_BYTE, 32'hAAAAAAAA);
        push(1, '0, 1'b0, 3'd0, '0);
        push(0, 32'h10, 1'b0, HSIZE_WORD, '0);
        push(0, 32'h12, 1'b1, HSIZE_HALF, 32'h55665566);
        push(1, '0, 1'b0, 3'd0, '0);
        push(0, 32'h10, 1'b0, HSIZE_WORD, '0);
        push(0, 32'h20, 1'b1, HSIZE_WORD, 32'hCAFEF00D);
        push(0, 32'h20, 1'b0, HSIZE_WORD, '0);
        push(0, 32'h02, 1'b0, HSIZE_WORD, '0);
        push(0, 32'h10, 1'b0, 3'd3, '0);
        push(0, 32'h11, 1'b1, HSIZE_HALF, 32'hFFFFFFFF);
        push(0, 32'h10, 1'b0, HSIZE_WORD, '0);
        push(0, 32'h1010, 1'b1, HSIZE_BYTE, 32'h77777777);
        push(0, 32'h10, 1'b0, HSIZE_WORD, '0);
        run_q(0);
        push_rand(300);
        run_q(0);

        // Three-wait instance.
        for (int i = 0; i < 32; i++) push(0, 32'(i * 4), 1'b1, HSIZE_WORD, $urandom);
        push(0, 32'h30, 1'b0, HSIZE_WORD, '0);
        push(0, 32'h02, 1'b0, HSIZE_WORD, '0);
        push(0, 32'h10, 1'b0, 3'd3, '0);
        push(0, 32'h11, 1'b1, HSIZE_HALF, 32'hFFFFFFFF);
        push(0, 32'h10, 1'b0, HSIZE_WORD, '0);
        push(0, 32'h24, 1'b1, HSIZE_WORD, 32'h0BADF00D);
        push(0, 32'h24, 1'b0, HSIZE_WORD, '0);
        run_q(1);
        push_rand(150);
        push(0, 32'h44, 1'b0, HSIZE_WORD, '0);
        run_q(1);

        // Reset while a write sits in its wait states: write must be dropped.
        hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; hwrite[1] = 1'b1;
        hsize[1] = HSIZE_WORD; haddr[1] = 32'h40;
        @(posedge clk); #1;
        drive_idle(1);
        hwdata[1] = 32'h99999999;
        @(negedge clk);
        chk("rst_mid_wait", 32'(hreadyout[1]), 32'd0);
        rstn[1] = 1'b0;
        @(posedge clk); #1;
        rstn[1] = 1'b1;
        @(negedge clk);
        chk("rst_mid_hreadyout", 32'(hreadyout[1]), 32'd1);
        chk("rst_mid_hresp", 32'(hresp[1]), 32'd0);
        chk("rst_mid_hrdata", hrdata[1], 32'd0);
        @(posedge clk); #1;
        push(0, 32'h40, 1'b0, HSIZE_WORD, '0);
        run_q(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

AHB-Lite responder that backs a word-organised, byte-writable SRAM on the SoC bus, sitting downstream of `ahb_lite_top`'s master port (via the address decoder's `hsel`) as the data memory for core LSU loads and stores. It accepts pipelined single transfers of byte, halfword or word size, inserts a configurable number of wait states, and returns an ERROR response for misaligned or oversized transfers. Reads return the full 32-bit word; the master extracts lanes.

## Interface
- `AW`, 10: word-address width; memory depth 2^AW words (default 4 KiB).
- `WAIT_STATES`, 0: wait cycles inserted in every OKAY data phase (0..15).
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `hsel` in 1: slave select from decoder.
- `haddr` in 32: byte address; bits [AW+1:2] index memory, higher bits ignored (aliasing).
- `htrans` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: 0 byte, 1 half, 2 word; ≥3 illegal.
- `hburst` in 3: ignored.
- `hwdata` in 32: write data, valid in data phase.
- `hready` in 1: bus-level ready (previous data phase done).
- `hreadyout` out 1: this slave's ready; reset 1.
- `hresp` out 1: 0 OKAY, 1 ERROR; reset 0.
- `hrdata` out 32: read data; reset 0.

## Operation
- Address phase accepted when `hsel & htrans[1] & hready`; latch addr, write, size, lane mask. IDLE/BUSY or unselected: no data phase, OKAY zero-wait.
- Legality: size ≥3, half with addr[0]=1, word with addr[1:0]≠0 → ERROR; no memory access.
- Lane mask: byte → 1<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
- FSM (registered): IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: accepted legal → WAIT if WAIT_STATES>0 (load counter WAIT_STATES-1) else DATA; illegal → ERR1.
  - WAIT: hreadyout=0, hresp=0; counter decrements; at 0 → DATA.
  - DATA: hreadyout=1, hresp=0; transfer completes; write commits `hwdata` lanes at this edge; if new transfer accepted this cycle, next state per IDLE rules, else IDLE.
  - ERR1: hreadyout=0, hresp=1 → ERR2. ERR2: hreadyout=1, hresp=1; new address phase may be accepted (master normally cancels to IDLE) → per IDLE rules.
- Reads: memory read issued at transfer's address accept, data held in `hrdata` register until next read completes; `hrdata` only meaningful when DATA with read.
- Forwarding: if a read is accepted in the same cycle a write to the same word commits, `hrdata` merges written lanes from `hwdata` over stored lanes.
- Write-then-read, different words: no interaction. Writes never disturb `hrdata`.
- `rstn` low mid-transfer: FSM→IDLE, outputs to reset values, pending write dropped; memory contents not reset.

## Timing
- WAIT_STATES=0: address in cycle N, data phase in N+1 with hreadyout=1; back-to-back transfers sustain 1/cycle.
- WAIT_STATES=k: data phase spans k+1 cycles, hreadyout low for first k.
- ERROR: always exactly 2 cycles, independent of WAIT_STATES.
- `hreadyout`, `hresp`, `hrdata` are flop outputs; no combinational path from inputs.

## Structure
- `ahb_lite_pkg`: HTRANS_*, HSIZE_*, HRESP_OKAY/ERROR constants, FSM state encoding, lane-mask function.
- Sub-module `sram_bytewen` (2^AW × 32, four byte-write enables, synchronous read, no reset) holds the array; slave holds FSM, address latch, counter, forwarding.

## Test plan
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 → hrdata 0xDEADBEEF, hreadyout never low, hresp 0.
- Byte write 0xAA @0x13 over word 0x11223344, read @0x10 → 0xAA223344; half write 0x5566 @0x12 → 0x55663344.
- Back-to-back write @0x20 (0xCAFEF00D) then read @0x20 next cycle → forwarded 0xCAFEF00D.
- WAIT_STATES=3: single read → hreadyout low exactly 3 cycles, then high with data.
- Word read @0x02 and hsize=3 → hresp=1 for 2 cycles (hreadyout 0 then 1); memory unchanged on misaligned write.
- Assert rstn low in WAIT during write → hreadyout=1, hresp=0, hrdata=0 next cycle; subsequent read shows old word.
